seg7_capture: RTL

Receive-side counterpart of the team's multiplexed 7-segment scanner. Samples the scanned active-low anode and segment buses, waits for each digit's dwell to settle, decodes the glyph back to a hex nibble, and holds per-digit value, valid and error registers. It is used for on-board loopback and self-check of the display path: the SEG/AN outputs are fed back into this block, and the recovered digits are compared against the ALU result.

---
 rtl/seg7_capture.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// seg7_capture
// Receive side of the multiplexed 7-segment scanner. Watches the scanned
// active-low anode/segment buses, waits for each digit's dwell to settle,
// decodes the glyph back to a hex nibble and keeps per-digit value, valid
// and error registers.
//
// Build option:
//   SEG7_CAPTURE_SYNC_EN - when defined, an and seg pass through 2-flop
//   synchronizers before sampling (+2 cycles latency). Leave undefined for
//   same-clock loopback, where the ports are sampled directly.
module seg7_capture #(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [6:0]                    seg,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         digit_err,
  output logic                          update,
  output logic [$clog2(NUM_DIGITS)-1:0] update_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = NUM_DIGITS + 7;
  // Run counter is 8 bits wide: STABLE_CYCLES never exceeds 255.
  localparam int RW = 8;
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_s;
  logic [6:0]            seg_s;

`ifdef SEG7_CAPTURE_SYNC_EN
  logic [NUM_DIGITS-1:0] an_meta, an_sync;
  logic [6:0]            seg_meta, seg_sync;

  // Two-flop synchronizers for pins driven from an unrelated clock domain.
  // NOTE: every flop here, including the synchronizer stages, is cleared by
  // reset so a dwell in progress at reset cannot leak through after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta  <= '0;
      an_sync  <= '0;
      seg_meta <= '0;
      seg_sync <= '0;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= seg;
      seg_sync <= seg_meta;
    end
  end

  assign an_s  = an_sync;
  assign seg_s = seg_sync;
`else
  assign an_s  = an;
  assign seg_s = seg;
`endif

  // Active-high views of the sampled buses.
  logic [NUM_DIGITS-1:0] an_ah;
  logic [6:0]            seg_ah;
  logic [SW-1:0]         s;
  logic                  qual;

  assign an_ah  = ~an_s;
  assign seg_ah = ~seg_s;
  assign s      = {an_ah, seg_ah};

  // A sample counts only when exactly one digit is selected.
  assign qual = (an_ah != '0) && ((an_ah & (an_ah - 1'b1)) == '0);

  // --------------------------------------------------------------------------
  // Selected-digit index and glyph decode
  // --------------------------------------------------------------------------
  logic [IW-1:0] sel_idx;

  // Convert the one-hot anode into a binary digit index.
  // NOTE: assign a default before any conditional write in combinational
  // logic; otherwise the unassigned paths infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_ah[i]) sel_idx = IW'(i);
    end
  end

  // Returns {recognised, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    r = 5'b0_0000;
    case (g)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [4:0] glyph;
  logic       glyph_hit;
  logic [3:0] glyph_nib;
  logic       glyph_blank;

  assign glyph       = decode_glyph(seg_ah);
  assign glyph_hit   = glyph[4];
  assign glyph_nib   = glyph[3:0];
  assign glyph_blank = (seg_ah == 7'h00);

  // --------------------------------------------------------------------------
  // Run counter: IDLE (0), SETTLE (1..STABLE-1), HELD (STABLE)
  // --------------------------------------------------------------------------
  logic [RW-1:0] run_q, run_next;
  logic [SW-1:0] prev_s;
  logic          capture;

  // Next run length and the single capture strobe of a dwell.
  always_comb begin
    run_next = '0;
    capture  = 1'b0;
    if (qual) begin
      if (run_q == '0 || s != prev_s) begin
        run_next = RW'(1);
      end else if (run_q != RUN_MAX) begin
        run_next = run_q + 1'b1;
      end else begin
        run_next = run_q;
      end
      // Only the transition into HELD captures; staying in HELD does not.
      capture = (run_next == RUN_MAX) && (run_q != RUN_MAX);
    end
  end

  // Run length and previous sample registers.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      prev_s <= '0;
    end else begin
      run_q  <= run_next;
      prev_s <= s;
    end
  end

  // --------------------------------------------------------------------------
  // Per-digit value/valid/error and age registers
  // --------------------------------------------------------------------------
  logic [AW-1:0] age_q [NUM_DIGITS];

  // Capture writes the selected digit; otherwise each age counter runs and
  // drops valid when it reaches the timeout. Capture takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_idx == IW'(i)) begin
          age_q[i] <= '0;
          if (glyph_hit) begin
            digits[4*i +: 4] <= glyph_nib;
            digit_valid[i]   <= 1'b1;
            digit_err[i]     <= 1'b0;
          end else begin
            digit_valid[i] <= 1'b0;
            digit_err[i]   <= !glyph_blank;
          end
        end else if (age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + 1'b1;
          if (age_q[i] == AGE_MAX - 1'b1) digit_valid[i] <= 1'b0;
        end
      end
    end
  end

  // One-cycle update pulse tagged with the written digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update     <= 1'b0;
      update_idx <= '0;
    end else begin
      update <= capture;
      if (capture) update_idx <= sel_idx;
    end
  end

endmodule
